one_two_tally: RTL and testbench

- Sequential stage directly downstream of the one_two_set classifier. It consumes its per-cycle "one"/"two" flags under a valid/ready handshake.
- Keeps saturating tallies of three outcomes: exactly-one, exactly-two, and other (zero or three inputs true).
- On a report request, it snapshots the tallies into a held result and handshakes that result out. The tallies then restart from zero.

---
 rtl/one_two_pkg.sv | 28 ++
 rtl/sat_counter.sv | 20 ++
 rtl/one_two_tally.sv | 92 +++++++++
 tb/tb_one_two_tally.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/one_two_pkg.sv
// Shared types and constants for the one/two classifier tally stage.
// Outcome codes name what one accepted classifier sample contributes to the tallies.
package one_two_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [1:0] OUT_ONE     = 2'd0;
  localparam logic [1:0] OUT_TWO     = 2'd1;
  localparam logic [1:0] OUT_OTHER   = 2'd2;
  localparam logic [1:0] OUT_ILLEGAL = 2'd3;

  function automatic logic [1:0] classify(input logic one, input logic two);
    logic [1:0] outcome;
    unique case ({one, two})
      2'b10:   outcome = OUT_ONE;
      2'b01:   outcome = OUT_TWO;
      2'b00:   outcome = OUT_OTHER;
      default: outcome = OUT_ILLEGAL;
    endcase
    return outcome;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/one_two_tally.sv
// Tallies classifier outcomes and hands out a snapshot on request.
// state | meaning
// COUNT | accepting samples; report takes a snapshot and clears the tallies
// HOLD  | snapshot presented on out_*, waiting for out_ready
module one_two_tally
  import one_two_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         one,
  input  logic         two,
  input  logic         report,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_one,
  output logic [W-1:0] out_two,
  output logic [W-1:0] out_other,
  output logic         err
);

  state_t     state_q, state_d;
  logic       accepted;
  logic [1:0] outcome;
  logic       inc_one, inc_two, inc_other;
  logic       take_snap;
  logic [W-1:0] cnt_one, cnt_two, cnt_other;
  logic [W-1:0] nxt_one, nxt_two, nxt_other;

  assign in_ready  = (state_q == COUNT);
  assign accepted  = in_valid && in_ready;
  assign outcome   = classify(one, two);
  assign inc_one   = accepted && (outcome == OUT_ONE);
  assign inc_two   = accepted && (outcome == OUT_TWO);
  assign inc_other = accepted && (outcome == OUT_OTHER);
  assign take_snap = (state_q == COUNT) && report;

  // The snapshot must include a sample accepted in the report cycle, so the
  // post-increment values are formed here rather than read from the counters.
  assign nxt_one   = (inc_one   && (cnt_one   != '1)) ? cnt_one   + 1'b1 : cnt_one;
  assign nxt_two   = (inc_two   && (cnt_two   != '1)) ? cnt_two   + 1'b1 : cnt_two;
  assign nxt_other = (inc_other && (cnt_other != '1)) ? cnt_other + 1'b1 : cnt_other;

  sat_counter #(.W(W)) u_cnt_one (
    .clk(clk), .reset(reset), .inc(inc_one), .clr(take_snap), .q(cnt_one)
  );

  sat_counter #(.W(W)) u_cnt_two (
    .clk(clk), .reset(reset), .inc(inc_two), .clr(take_snap), .q(cnt_two)
  );

  sat_counter #(.W(W)) u_cnt_other (
    .clk(clk), .reset(reset), .inc(inc_other), .clr(take_snap), .q(cnt_other)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COUNT:   if (report) state_d = HOLD;
      HOLD:    if (out_ready) state_d = COUNT;
      default: state_d = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COUNT;
      out_valid <= 1'b0;
      out_one   <= '0;
      out_two   <= '0;
      out_other <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_snap) begin
        out_one   <= nxt_one;
        out_two   <= nxt_two;
        out_other <= nxt_other;
        out_valid <= 1'b1;
      end else if ((state_q == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accepted && (outcome == OUT_ILLEGAL)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_one_two_tally.sv
// Bench for one_two_tally: W=8 and W=3 instances share stimulus; a tally model
// predicts snapshots into a queue that a separate monitor drains and compares.
module tb_one_two_tally;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, one = 1'b0, two = 1'b0, report = 1'b0, out_ready = 1'b0;

  logic       in_ready8, out_valid8, err8;
  logic [7:0] o1_8, o2_8, oo_8;
  logic       in_ready3, out_valid3, err3;
  logic [2:0] o1_3, o2_3, oo_3;

  always #5 clk = ~clk;

  one_two_tally #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .one(one), .two(two), .report(report), .out_valid(out_valid8),
    .out_ready(out_ready), .out_one(o1_8), .out_two(o2_8), .out_other(oo_8),
    .err(err8)
  );

  one_two_tally #(.W(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .one(one), .two(two), .report(report), .out_valid(out_valid3),
    .out_ready(out_ready), .out_one(o1_3), .out_two(o2_3), .out_other(oo_3),
    .err(err3)
  );

  typedef struct {
    int c1;
    int c2;
    int co;
  } snap_t;

  snap_t exp_q[$];
  snap_t m_last = '{0, 0, 0};
  snap_t popped;
  int    m_c1 = 0, m_c2 = 0, m_co = 0;
  bit    m_hold = 1'b0, m_err = 1'b0;
  bit    prev_valid = 1'b0;
  int    n_vec = 0, n_fail = 0;

  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Inputs change at the falling edge; the model then predicts the state
  // that the next rising edge produces.
  task automatic step(input bit r, input bit iv, input bit o, input bit t,
                      input bit rep, input bit ordy);
    @(negedge clk);
    reset = r; in_valid = iv; one = o; two = t; report = rep; out_ready = ordy;
    if (r) begin
      m_c1 = 0; m_c2 = 0; m_co = 0;
      m_hold = 1'b0; m_err = 1'b0;
      m_last = '{0, 0, 0};
      exp_q.delete();
    end else if (!m_hold) begin
      if (iv) begin
        if (o && t)  m_err = 1'b1;
        else if (o)  m_c1++;
        else if (t)  m_c2++;
        else         m_co++;
      end
      if (rep) begin
        m_last = '{m_c1, m_c2, m_co};
        exp_q.push_back(m_last);
        m_c1 = 0; m_c2 = 0; m_co = 0;
        m_hold = 1'b1;
      end
    end else if (ordy) begin
      m_hold = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    check("in_ready8", in_ready8, !m_hold);
    check("in_ready3", in_ready3, !m_hold);
    check("out_valid8", out_valid8, m_hold);
    check("out_valid3", out_valid3, m_hold);
    check("err8", err8, m_err);
    check("err3", err3, m_err);
    if (out_valid8 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL snap_pending: out_valid rose, got 1 snapshot, expected 0");
      end else begin
        popped = exp_q.pop_front();
        check("snap_one8",   o1_8, sat(popped.c1, 8));
        check("snap_two8",   o2_8, sat(popped.c2, 8));
        check("snap_other8", oo_8, sat(popped.co, 8));
        check("snap_one3",   o1_3, sat(popped.c1, 3));
        check("snap_two3",   o2_3, sat(popped.c2, 3));
        check("snap_other3", oo_3, sat(popped.co, 3));
      end
    end
    check("held_one8",   o1_8, sat(m_last.c1, 8));
    check("held_two8",   o2_8, sat(m_last.c2, 8));
    check("held_other8", oo_8, sat(m_last.co, 8));
    check("held_one3",   o1_3, sat(m_last.c1, 3));
    check("held_two3",   o2_3, sat(m_last.c2, 3));
    check("held_other3", oo_3, sat(m_last.co, 3));
    prev_valid = out_valid8;
  end

  initial begin
    bit r, iv, o, t, rep, ordy;
    int k;

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // 10,10,01,00 then a bare report; one dropped sample while held
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);

    // report coinciding with a sample, fastest handshake, then an empty report
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    // nine one-samples saturate the narrow instance
    for (int i = 0; i < 9; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    // illegal sample, then illegal sample together with report
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);

    // stalled consumer with traffic, then reset while held
    step(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // saturate the wide instance
    for (int i = 0; i < 300; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 499) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      k    = $urandom_range(0, 63);
      if (k == 0) begin
        o = 1'b1; t = 1'b1;
      end else begin
        o = (k % 3 == 1);
        t = (k % 3 == 2);
      end
      rep  = ($urandom_range(0, 15) == 0);
      ordy = $urandom_range(0, 1) != 0;
      step(r, iv, o, t, rep, ordy);
    end

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
